instr_fetch: RTL and testbench

//  Fetch stage of the CPU: owns the PC and issues one instruction-memory read at a time.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_pc_sel.sv | 25 ++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch stage
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - redirect priority mux, target alignment and sequential PC increment
module fetch_pc_sel #(
  parameter int ADDR_W = 32
) (
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] seq_pc,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] seq_pc_plus4
);

  logic [ADDR_W-1:0] raw_target;

  always_comb begin
    redirect     = jump | branch_taken;
    raw_target   = jump ? jump_target : branch_target;
    redirect_pc  = {raw_target[ADDR_W-1:2], 2'b00};
    // Wraps modulo 2^ADDR_W by construction.
    seq_pc_plus4 = seq_pc + ADDR_W'(4);
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: owns the PC, one outstanding imem read, registered ins to decode
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [INSTR_W-1:0] ins,
  output logic [ADDR_W-1:0]  ins_pc,
  output logic               ins_valid
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] ins_q, ins_d;
  logic [ADDR_W-1:0]  ins_pc_q, ins_pc_d;
  logic               ins_valid_q, ins_valid_d;

  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  inflight_pc_plus4;
  logic               accept;

  fetch_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .seq_pc        (inflight_pc_q),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .seq_pc_plus4  (inflight_pc_plus4)
  );

  // A held, stalled instruction blocks the next request so ins never gets overwritten.
  always_comb begin
    imem_req  = (state_q == FETCH) & (~ins_valid_q | ~stall) & ~reset;
    imem_addr = pc_q;
    accept    = imem_req & imem_ready;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    drop_d        = drop_q;
    ins_d         = ins_q;
    ins_pc_d      = ins_pc_q;
    ins_valid_d   = ins_valid_q & stall;

    case (state_q)
      FETCH: begin
        if (accept) begin
          state_d       = WAIT;
          inflight_pc_d = pc_q;
          drop_d        = redirect;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            ins_d       = imem_rdata;
            ins_pc_d    = inflight_pc_q;
            ins_valid_d = 1'b1;
            pc_d        = inflight_pc_plus4;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect flushes the held instruction even under stall.
    if (redirect) begin
      pc_d        = redirect_pc;
      ins_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      ins_q         <= '0;
      ins_pc_q      <= '0;
      ins_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      ins_q         <= ins_d;
      ins_pc_q      <= ins_pc_d;
      ins_valid_q   <= ins_valid_d;
    end
  end

  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign ins_valid = ins_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch with a small imem responder
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [31:0] mem_addr_q = '0;

  instr_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .ins           (ins),
    .ins_pc        (ins_pc),
    .ins_valid     (ins_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: capture an accept before the edge, present the response mem_lat cycles later.
  task automatic tick();
    #1;
    if (imem_req && imem_ready) begin
      mem_busy   = 1'b1;
      mem_cnt    = mem_lat;
      mem_addr_q = imem_addr;
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_q);
        mem_busy    = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    imem_ready = 1'b1; mem_lat = 1;
    tick();
    imem_rvalid = 1'b0; mem_busy = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_first_req", {31'b0, imem_req}, 32'd1);
    chk("rst_first_addr", imem_addr, RST_PC);
  endtask

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_t;
    logic        jmp;
    logic [31:0] jmp_t;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle-by-cycle from cycle 1 after reset, 1-cycle memory, ready=1.
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0,   32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h000, 1'b0, 32'h0,   32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h0,   32'h8C00_0000};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h004, 1'b0, 32'h0,   32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h4,   32'h8C00_0004};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h4,   32'h8C00_0004};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h4,   32'h8C00_0004};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h4,   32'h8C00_0004};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h008, 1'b0, 32'h0,   32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h8,   32'h8C00_0008};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h103, 1'b0, 32'h00C, 1'b0, 32'h0,   32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   32'h0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0,   32'h0};
    vecs[13] = '{1'b1, 1'b1, 32'h40, 1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h100, 32'h8C00_0100};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h080, 1'b0, 32'h0,   32'h0};
    vecs[15] = '{1'b0, 1'b1, 32'h41, 1'b0, 32'h0,   1'b0, 32'h080, 1'b0, 32'h0,   32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h040, 1'b0, 32'h0,   32'h0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      stall = vecs[i].stall;
      branch_taken = vecs[i].br; branch_target = vecs[i].br_t;
      jump = vecs[i].jmp; jump_target = vecs[i].jmp_t;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, ins_valid}, {31'b0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_ins_pc", i), ins_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_ins", i), ins, vecs[i].e_ins);
      end
      tick();
    end

    // Redirect while waiting on a slow response: the late data must be dropped.
    do_reset();
    mem_lat = 2;
    tick();
    jump = 1'b1; jump_target = 32'h103;
    #1;
    chk("drop_wait_req", {31'b0, imem_req}, 32'd0);
    tick();
    jump = 1'b0;
    #1;
    chk("drop_resp_req", {31'b0, imem_req}, 32'd0);
    chk("drop_resp_valid", {31'b0, ins_valid}, 32'd0);
    tick();
    #1;
    chk("drop_after_valid", {31'b0, ins_valid}, 32'd0);
    chk("drop_after_ins", ins, 32'd0);
    chk("drop_after_req", {31'b0, imem_req}, 32'd1);
    chk("drop_after_addr", imem_addr, 32'h100);

    // Redirect on the same edge as an accept.
    do_reset();
    jump = 1'b1; jump_target = 32'h200;
    #1;
    chk("accredir_req", {31'b0, imem_req}, 32'd1);
    tick();
    jump = 1'b0;
    #1;
    chk("accredir_wait_valid", {31'b0, ins_valid}, 32'd0);
    tick();
    #1;
    chk("accredir_valid", {31'b0, ins_valid}, 32'd0);
    chk("accredir_addr", imem_addr, 32'h200);
    chk("accredir_req2", {31'b0, imem_req}, 32'd1);

    // PC wrap at the top of the address space, with unaligned target.
    do_reset();
    imem_ready = 1'b0;
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick();
    jump = 1'b0; imem_ready = 1'b1;
    #1;
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req_top", {31'b0, imem_req}, 32'd1);
    tick();
    tick();
    #1;
    chk("wrap_valid", {31'b0, ins_valid}, 32'd1);
    chk("wrap_ins_pc", ins_pc, 32'hFFFF_FFFC);
    chk("wrap_ins", ins, 32'h73FF_FFFC);
    chk("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Reset while a stalled instruction is held.
    stall = 1'b1;
    #1;
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    imem_rvalid = 1'b0; mem_busy = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ins_valid}, 32'd0);
    chk("midrst_ins", ins, 32'd0);
    chk("midrst_ins_pc", ins_pc, 32'd0);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("midrst_after_req", {31'b0, imem_req}, 32'd1);
    chk("midrst_after_addr", imem_addr, RST_PC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
